question_bank: RTL and testbench

Parametrised bank of `NUM_BLOCKS` question blocks shared by `NUM_PLAYERS` players. It is the successor to the single-block question module.
- Each block has its own level number, position and hit budget, so it can give more than one hit before it goes empty.
- With the configuration macro enabled, a hit plays a frame-counted bump animation.
- The bank sits between the player motion modules and the sprite/colour mapper. It returns the per-pixel draw flags, the ROM address and one-cycle hit pulses for score and coin logic.

---
 rtl/question_pkg.sv | 7 +
 rtl/question_cell.sv | 77 +++++++
 rtl/question_bank.sv | 86 ++++++++
 tb/tb_question_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/question_pkg.sv
// question_pkg: block state encoding and hit/park geometry shared by the question bank
package question_pkg;
  typedef enum logic [1:0] {Q_FULL, Q_BUMP, Q_EMPTY} q_state_t;
  localparam logic [9:0] PARK_X = 10'd800;
  localparam int HEAD_HALF_W = 7;
  localparam int HEAD_MIN_OFS = 9;
endpackage

// File: rtl/question_cell.sv
// question_cell: one block's position, head-hit test, FULL/BUMP/EMPTY FSM and bump counter (QUESTION_BUMP_EN)
module question_cell
  import question_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int BLOCK_SIZE = 20,
  parameter int HITS_PER_BLOCK = 1
`ifdef QUESTION_BUMP_EN
  , parameter int BUMP_FRAMES = 8
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       active,
  input  logic [9:0] block_x,
  input  logic [9:0] block_y,
  input  logic [9:0] player_x      [NUM_PLAYERS],
  input  logic [9:0] player_y      [NUM_PLAYERS],
  input  logic [9:0] player_size_y [NUM_PLAYERS],
  input  logic [1:0] player_health [NUM_PLAYERS],
  output logic [9:0] bx,
  output logic [9:0] by,
  output logic       up,
  output logic       empty,
  output logic       hit_pulse
);
  q_state_t state;
  logic [3:0] hits_left;
  logic hit;
  // any live player's head inside the window counts once; 11-bit math keeps sums from wrapping
  always_comb begin
    hit = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      hit = hit | (player_health[p] != 2'd0
        && 11'(player_x[p]) + 11'(HEAD_HALF_W) >= 11'(bx)
        && 11'(player_x[p]) <= 11'(bx) + 11'(BLOCK_SIZE) + 11'(HEAD_HALF_W)
        && 11'(player_y[p]) - 11'(player_size_y[p]) > 11'(by) + 11'(HEAD_MIN_OFS)
        && 11'(player_y[p]) - 11'(player_size_y[p]) <= 11'(by) + 11'(BLOCK_SIZE) + 11'd1);
    hit = hit && active && state == Q_FULL;
  end
  assign empty = state == Q_EMPTY;
`ifdef QUESTION_BUMP_EN
  localparam int CW = BUMP_FRAMES > 2 ? $clog2(BUMP_FRAMES) : 1;
  logic [CW-1:0] bump_cnt;
  logic bump_last;
  assign bump_last = bump_cnt == CW'(BUMP_FRAMES - 1);
  assign up = state == Q_BUMP && bump_cnt < CW'(BUMP_FRAMES / 2);
  always_ff @(posedge Clk)
    if (!Reset) bump_cnt <= '0;
    else if (tick && state == Q_BUMP) bump_cnt <= bump_last ? '0 : bump_cnt + CW'(1);
`else
  assign up = 1'b0;
`endif
  // FSM state survives inactivity so an emptied block stays empty across level changes
  always_ff @(posedge Clk)
    if (!Reset) begin
      state     <= Q_FULL;
      hits_left <= 4'(HITS_PER_BLOCK);
      bx        <= PARK_X;
      by        <= 10'd0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= tick && hit;
      if (tick) begin
        bx <= active ? block_x : PARK_X;
        by <= active ? block_y : 10'd0;
        if (hit) hits_left <= hits_left - 4'd1;
`ifdef QUESTION_BUMP_EN
        if (hit) state <= Q_BUMP;
        else if (state == Q_BUMP && bump_last) state <= hits_left == 4'd0 ? Q_EMPTY : Q_FULL;
`else
        if (hit && hits_left == 4'd1) state <= Q_EMPTY;
`endif
      end
    end
endmodule

// File: rtl/question_bank.sv
// question_bank: bank of question blocks - frame tick sync, per-block cells, priority render mux.
// Define QUESTION_BUMP_EN for the frame-counted bump animation on each hit.
module question_bank
  import question_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int BLOCK_SIZE = 20,
  parameter int HITS_PER_BLOCK = 1,
  parameter int BUMP_FRAMES = 8,
  parameter int BUMP_HEIGHT = 4
) (
  input  logic                                    Clk,
  input  logic                                    Reset,
  input  logic                                    frame_clk,
  input  logic [9:0]                              DrawX,
  input  logic [9:0]                              DrawY,
  input  logic [2:0]                              level_num,
  input  logic [2:0]                              block_level_num [NUM_BLOCKS],
  input  logic [9:0]                              block_x         [NUM_BLOCKS],
  input  logic [9:0]                              block_y         [NUM_BLOCKS],
  input  logic [9:0]                              player_x        [NUM_PLAYERS],
  input  logic [9:0]                              player_y        [NUM_PLAYERS],
  input  logic [9:0]                              player_size_y   [NUM_PLAYERS],
  input  logic [1:0]                              player_health   [NUM_PLAYERS],
  output logic                                    is_question,
  output logic                                    is_question_empty,
  output logic [$clog2(BLOCK_SIZE*BLOCK_SIZE)-1:0] question_address,
  output logic [NUM_BLOCKS-1:0]                   hit_pulse
);
  localparam int AW = $clog2(BLOCK_SIZE * BLOCK_SIZE);
  logic [2:0] sync;
  logic tick;
  logic [9:0] bx [NUM_BLOCKS];
  logic [9:0] by [NUM_BLOCKS];
  logic [9:0] ydraw [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] up, empty;
  always_ff @(posedge Clk)
    if (!Reset) begin
      sync <= 3'd0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[1:0], frame_clk};
      tick <= sync[1] & ~sync[2];
    end
  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_cell
    question_cell #(
      .NUM_PLAYERS(NUM_PLAYERS),
      .BLOCK_SIZE(BLOCK_SIZE),
      .HITS_PER_BLOCK(HITS_PER_BLOCK)
`ifdef QUESTION_BUMP_EN
      , .BUMP_FRAMES(BUMP_FRAMES)
`endif
    ) u_cell (
      .Clk(Clk),
      .Reset(Reset),
      .tick(tick),
      .active(block_level_num[i] == level_num),
      .block_x(block_x[i]),
      .block_y(block_y[i]),
      .player_x(player_x),
      .player_y(player_y),
      .player_size_y(player_size_y),
      .player_health(player_health),
      .bx(bx[i]),
      .by(by[i]),
      .up(up[i]),
      .empty(empty[i]),
      .hit_pulse(hit_pulse[i])
    );
    assign ydraw[i] = by[i] - (up[i] ? 10'(BUMP_HEIGHT) : 10'd0);
  end
  // scan from the top index down so the lowest covering block is the one left standing
  always_comb begin
    is_question = 1'b0;
    is_question_empty = 1'b0;
    question_address = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--)
      if (Reset && DrawX >= bx[i] && 11'(DrawX) < 11'(bx[i]) + 11'(BLOCK_SIZE)
          && DrawY >= ydraw[i] && 11'(DrawY) < 11'(ydraw[i]) + 11'(BLOCK_SIZE)) begin
        is_question = 1'b1;
        is_question_empty = empty[i];
        question_address = AW'(DrawX - bx[i]) + AW'(DrawY - ydraw[i]) * AW'(BLOCK_SIZE);
      end
  end
endmodule

// File: tb/tb_question_bank.sv
// tb_question_bank: directed table plus randomized hits checked against a per-block tick model
module tb_question_bank;
  localparam int NB = 4, NP = 2, BS = 20, HPB = 3, BF = 8, BH = 4;
  typedef struct {int x; int y; bit q; bit e; int a;} vec_t;
  logic Clk, Reset, frame_clk;
  logic [9:0] DrawX, DrawY;
  logic [2:0] level_num;
  logic [2:0] block_level_num [NB];
  logic [9:0] block_x [NB];
  logic [9:0] block_y [NB];
  logic [9:0] player_x [NP];
  logic [9:0] player_y [NP];
  logic [9:0] player_size_y [NP];
  logic [1:0] player_health [NP];
  logic is_question, is_question_empty;
  logic [8:0] question_address;
  logic [NB-1:0] hit_pulse;
  int checks = 0, errors = 0;
  int pcnt [NB];
  int m_hits [NB], m_left [NB], m_x [NB], m_y [NB], m_pulses [NB];
  bit m_empty [NB];
  vec_t tbl [11];

  question_bank #(.NUM_BLOCKS(NB), .NUM_PLAYERS(NP), .BLOCK_SIZE(BS), .HITS_PER_BLOCK(HPB),
                  .BUMP_FRAMES(BF), .BUMP_HEIGHT(BH)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .level_num(level_num), .block_level_num(block_level_num), .block_x(block_x), .block_y(block_y),
    .player_x(player_x), .player_y(player_y), .player_size_y(player_size_y),
    .player_health(player_health), .is_question(is_question), .is_question_empty(is_question_empty),
    .question_address(question_address), .hit_pulse(hit_pulse));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(negedge Clk) for (int i = 0; i < NB; i++) if (hit_pulse[i]) pcnt[i]++;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_hits[i] = HPB; m_left[i] = 0; m_empty[i] = 0; m_x[i] = 800; m_y[i] = 0;
    end
  endtask

  function automatic bit m_hit(int i);
    int px, head;
    for (int p = 0; p < NP; p++) begin
      px = int'(player_x[p]);
      head = int'(player_y[p]) - int'(player_size_y[p]);
      if (player_health[p] != 0 && px + 7 >= m_x[i] && px <= m_x[i] + BS + 7
          && head > m_y[i] + 9 && head <= m_y[i] + BS + 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_ofs(int i);
`ifdef QUESTION_BUMP_EN
    return (m_left[i] > 0 && BF - m_left[i] < BF / 2) ? BH : 0;
`else
    return 0;
`endif
  endfunction

  // one frame tick: m_left counts the bump ticks still to run after the hit
  task automatic model_step();
    bit act;
    for (int i = 0; i < NB; i++) begin
      act = block_level_num[i] == level_num;
      if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 0 && m_hits[i] == 0) m_empty[i] = 1;
      end else if (act && !m_empty[i] && m_hit(i)) begin
        m_hits[i]--;
        m_pulses[i]++;
`ifdef QUESTION_BUMP_EN
        m_left[i] = BF;
`else
        if (m_hits[i] == 0) m_empty[i] = 1;
`endif
      end
      m_x[i] = act ? int'(block_x[i]) : 800;
      m_y[i] = act ? int'(block_y[i]) : 0;
    end
  endtask

  task automatic check_px(int x, int y, string nm);
    bit q = 0, e = 0;
    int a = 0, yd;
    DrawX = 10'(x); DrawY = 10'(y); #1;
    for (int i = 0; i < NB && !q; i++) begin
      yd = m_y[i] - m_ofs(i);
      if (x >= m_x[i] && x < m_x[i] + BS && y >= yd && y < yd + BS) begin
        q = 1; e = m_empty[i]; a = (x - m_x[i]) + (y - yd) * BS;
      end
    end
    chk({nm, " is_question"}, int'(is_question), int'(q));
    chk({nm, " empty"}, int'(is_question_empty), int'(e));
    chk({nm, " address"}, int'(question_address), a);
  endtask

  task automatic check_const(int x, int y, bit q, bit e, int a, string nm);
    DrawX = 10'(x); DrawY = 10'(y); #1;
    chk({nm, " is_question"}, int'(is_question), int'(q));
    chk({nm, " empty"}, int'(is_question_empty), int'(e));
    chk({nm, " address"}, int'(question_address), a);
  endtask

  task automatic do_tick(string nm);
    model_step();
    frame_clk = 1'b1; repeat (6) @(posedge Clk); #1;
    frame_clk = 1'b0; repeat (3) @(posedge Clk); #1;
    chk({nm, " pulse idle"}, int'(hit_pulse), 0);
    for (int i = 0; i < NB; i++) chk($sformatf("%s pulses[%0d]", nm, i), pcnt[i], m_pulses[i]);
  endtask

  task automatic do_reset();
    Reset = 1'b0; repeat (2) @(posedge Clk); #1;
    model_reset();
    Reset = 1'b1;
  endtask

  task automatic players_dead();
    for (int p = 0; p < NP; p++) begin
      player_x[p] = 10'd0; player_y[p] = 10'd0; player_size_y[p] = 10'd0; player_health[p] = 2'd0;
    end
  endtask

  initial begin
    int p1, p2, b, x, y;
    tbl = '{'{105, 203, 1, 0, 65}, '{99, 203, 0, 0, 0}, '{119, 219, 1, 0, 399},
            '{120, 203, 0, 0, 0}, '{100, 199, 0, 0, 0}, '{305, 210, 1, 0, 205},
            '{325, 205, 1, 0, 105}, '{315, 215, 1, 0, 315}, '{325, 215, 1, 0, 305},
            '{329, 229, 1, 0, 399}, '{330, 205, 1, 0, 110}};
    Reset = 1'b0; frame_clk = 1'b0; level_num = 3'd0; DrawX = 10'd810; DrawY = 10'd5;
    block_x = '{10'd100, 10'd300, 10'd320, 10'd310};
    block_y = '{10'd200, 10'd200, 10'd200, 10'd210};
    block_level_num = '{3'd1, 3'd1, 3'd1, 3'd1};
    players_dead();
    model_reset();
    repeat (3) @(posedge Clk); #1;
    chk("reset is_question", int'(is_question), 0);
    chk("reset empty", int'(is_question_empty), 0);
    chk("reset address", int'(question_address), 0);
    chk("reset hit_pulse", int'(hit_pulse), 0);
    Reset = 1'b1;
    check_px(105, 203, "parked after reset");

    level_num = 3'd1;
    do_tick("level1 a");
    do_tick("level1 b");
    for (int i = 0; i < 11; i++)
      check_const(tbl[i].x, tbl[i].y, tbl[i].q, tbl[i].e, tbl[i].a, $sformatf("table %0d", i));

    player_x[0] = 10'd100; player_y[0] = 10'd235; player_size_y[0] = 10'd20; player_health[0] = 2'd1;
    do_tick("first hit");
    chk("first hit count", pcnt[0], 1);
`ifdef QUESTION_BUMP_EN
    check_const(105, 196, 1, 0, 5, "bump raised");
`else
    check_const(105, 196, 0, 0, 0, "no bump raise");
`endif
    for (int t = 0; t < 40; t++) begin
      do_tick($sformatf("hold %0d", t));
      check_px(105, 197, $sformatf("hold px %0d", t));
    end
    chk("held hit total", pcnt[0], 3);
    check_const(105, 203, 1, 1, 65, "block0 empty");

    players_dead();
    level_num = 3'd2;
    do_tick("level2");
    check_const(105, 203, 0, 0, 0, "level2 block0 parked");
    check_const(315, 215, 0, 0, 0, "level2 block1 parked");
    level_num = 3'd1;
    do_tick("back a");
    do_tick("back b");
    check_const(105, 203, 1, 1, 65, "block0 still empty");

    player_x[0] = 10'd300; player_y[0] = 10'd235; player_size_y[0] = 10'd20;
    player_x[1] = 10'd315; player_y[1] = 10'd235; player_size_y[1] = 10'd20;
    p1 = pcnt[1]; p2 = pcnt[2];
    do_tick("dead players");
    chk("dead block1 delta", pcnt[1] - p1, 0);
    chk("dead block2 delta", pcnt[2] - p2, 0);
    player_health[0] = 2'd1; player_health[1] = 2'd2;
    do_tick("shared hit");
    chk("shared block1 delta", pcnt[1] - p1, 1);
    chk("shared block2 delta", pcnt[2] - p2, 1);

    players_dead();
    do_reset();
    do_tick("after reset");
    check_const(305, 203, 1, 0, 65, "reset block1 full");
    check_const(305, 198, 0, 0, 0, "reset block1 unraised");
    check_const(105, 203, 1, 0, 65, "reset block0 full");

    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      level_num = ($urandom_range(0, 3) == 0) ? 3'd2 : 3'd1;
      for (int p = 0; p < NP; p++) begin
        b = int'($urandom_range(0, NB - 1));
        player_x[p] = 10'(int'(block_x[b]) + int'($urandom_range(0, 44)) - 10);
        player_y[p] = 10'(int'(block_y[b]) + 20 + int'($urandom_range(0, 20)));
        player_size_y[p] = 10'd20;
        player_health[p] = 2'($urandom_range(0, 3));
      end
      do_tick($sformatf("rnd %0d", it));
      b = int'($urandom_range(0, NB - 1));
      x = int'(block_x[b]) + int'($urandom_range(0, 24)) - 2;
      y = int'(block_y[b]) + int'($urandom_range(0, 28)) - 6;
      check_px(x, y, $sformatf("rnd px %0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
